// File: rtl/arm_fetch_pkg.sv
// rtl/arm_fetch_pkg.sv - shared types and defaults for the instruction fetch controller
package arm_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - instruction buffer holding fetched words with their PCs
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [31:0]   push_instr,
    input  logic [31:0]   push_pc,
    input  logic          pop,
    input  logic          clear,
    output logic [31:0]   head_instr,
    output logic [31:0]   head_pc,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc_mem    [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    assign head_instr = instr_mem[rd_ptr];
    assign head_pc    = pc_mem[rd_ptr];
    assign empty      = (count == '0);
    assign full       = (count == CW'(DEPTH));

    // Pointer and occupancy tracking; clear wins over push and pop.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
        end
    end

    // Entry storage; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            instr_mem[wr_ptr] <= push_instr;
            pc_mem[wr_ptr]    <= push_pc;
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - PC sequencing, memory request issue and redirect handling
module imem_fetch_ctrl
    import arm_fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        br_taken,
    input  logic [31:0] br_addr,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e  state;
    fetch_state_e  state_next;
    logic [31:0]   fpc;
    logic [31:0]   req_pc;
    logic          inflight;

    logic          redirect;
    logic          pop;
    logic          push;
    logic          inflight_kept;
    logic [CW:0]   occupancy;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic [31:0]   head_instr;
    logic [31:0]   head_pc;

    // Branches are only honoured once the controller has left BOOT.
    assign redirect      = br_taken && (state != BOOT);
    assign if_valid      = !empty;
    assign pop           = if_valid && if_ready && !redirect;
    assign inflight_kept = inflight && (state != FLUSH);
    assign push          = inflight_kept && !redirect && (!full || pop);

    // Entries the buffer will hold once this cycle's pop and returning word settle.
    assign occupancy = {1'b0, count} - {{CW{1'b0}}, pop} + {{CW{1'b0}}, inflight_kept};
    assign mem_req   = (state != BOOT) && !redirect && (occupancy < (CW+1)'(DEPTH));
    assign mem_addr  = fpc;

    assign if_instr = if_valid ? head_instr : 32'h0;
    assign if_pc    = if_valid ? head_pc    : 32'h0;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Next state: a redirect that catches a response in flight passes through FLUSH.
    always_comb begin
        state_next = state;
        case (state)
            BOOT:       state_next = RUN;
            RUN, FLUSH: state_next = (redirect && inflight) ? FLUSH : RUN;
            default:    state_next = BOOT;
        endcase
    end

    // PC, outstanding-request flag and the PC that the returning word belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpc      <= RESET_PC;
            req_pc   <= RESET_PC;
            inflight <= 1'b0;
        end else begin
            inflight <= mem_req;
            if (mem_req) begin
                req_pc <= fpc;
            end
            if (redirect) begin
                fpc <= br_addr & 32'hFFFF_FFFC;
            end else if (mem_req) begin
                fpc <= fpc + 32'd4;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_instr (mem_rdata),
        .push_pc    (req_pc),
        .pop        (pop),
        .clear      (redirect),
        .head_instr (head_instr),
        .head_pc    (head_pc),
        .full       (full),
        .empty      (empty),
        .count      (count)
    );

endmodule
